// File: rtl/col_readout_pkg.sv
// Shared definitions for the column readout sequencer.
// Optional feature macro: COLRD_PARITY_EN (adds an even-parity MSB to captured words).
package col_readout_pkg;

  // Sequencer states, in the order a scan normally walks through them.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    CAPTURE,
    READ,
    RELEASE,
    DONE
  } state_t;

  // Position of the load strobe on the broadcast bus.
  localparam int BCST_LOAD_BIT = 0;

  // Position of the aggregated unread-hit flag in the chain hit vector.
  localparam int UNREAD_HIT_BIT = 0;

endpackage

// File: rtl/col_readout_outreg.sv
// Output holding register for the column readout sequencer.
// It holds one captured word and runs the valid/ready handshake toward the global readout.
// With COLRD_PARITY_EN defined, the word gains an MSB that is the XOR of the captured data.
module col_readout_outreg
  import col_readout_pkg::*;
#(
  parameter int DATAWIDTH = 46
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [DATAWIDTH-1:0] raw_data,
  input  logic                 ready,
`ifdef COLRD_PARITY_EN
  output logic [DATAWIDTH:0]   word,
`else
  output logic [DATAWIDTH-1:0] word,
`endif
  output logic                 valid,
  output logic                 can_load
);

  // A new word may enter when the register is empty or is being drained this cycle.
  assign can_load = !valid || ready;

  // Load on capture (wins over a same-cycle drain, so there is no bubble); else clear on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
`ifdef COLRD_PARITY_EN
      word  <= {^raw_data, raw_data};
`else
      word  <= raw_data;
`endif
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/col_readout_sequencer.sv
// Column readout sequencer: sits at the downstream end of a pixel column's switch-cell chain,
// loads the chain, then captures and retires hit pixels one at a time in priority order.
// Optional feature macro: COLRD_PARITY_EN (outData widens by one parity bit).
module col_readout_sequencer
  import col_readout_pkg::*;
#(
  parameter int DATAWIDTH = 46,
  parameter int HITSWIDTH = 5,
  parameter int BCSTWIDTH = 12,
  parameter int SETTLECYC = 3,
  parameter int READCYC   = 2,
  parameter int MAXREADS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           scanStart,
  input  logic [BCSTWIDTH-2:0]           bcstCfg,
  input  logic [HITSWIDTH-1:0]           dnHits,
  input  logic [DATAWIDTH-1:0]           dnData,
  output logic                           dnRead,
  output logic [BCSTWIDTH-1:0]           dnBCST,
`ifdef COLRD_PARITY_EN
  output logic [DATAWIDTH:0]             outData,
`else
  output logic [DATAWIDTH-1:0]           outData,
`endif
  output logic                           outValid,
  input  logic                           outReady,
  output logic                           scanBusy,
  output logic                           scanDone,
  output logic [$clog2(MAXREADS+1)-1:0]  readCount,
  output logic                           overflow
);

  localparam int CNTW    = $clog2(MAXREADS + 1);
  localparam int WAITMAX = (SETTLECYC > READCYC) ? SETTLECYC : READCYC;
  localparam int WAITW   = (WAITMAX > 1) ? $clog2(WAITMAX) : 1;

  localparam logic [WAITW-1:0] SETTLE_LAST = WAITW'(SETTLECYC - 1);
  localparam logic [WAITW-1:0] READ_LAST   = WAITW'(READCYC - 1);
  localparam logic [CNTW-1:0]  READ_LIMIT  = CNTW'(MAXREADS);

  state_t                state;
  logic [WAITW-1:0]      wait_cnt;
  logic                  load_strobe;
  logic [BCSTWIDTH-2:0]  bcst_cfg_q;
  logic                  hit_pending;
  logic                  can_load;
  logic                  capture;
  logic                  unused_trigger_hits;

  // Trigger hit bits ride along on the chain but this block has no use for them.
  assign unused_trigger_hits = ^dnHits[HITSWIDTH-1:1];

  assign hit_pending = dnHits[UNREAD_HIT_BIT];
  assign scanBusy    = (state != IDLE);

  // Data is latched in CAPTURE, one cycle before dnRead clears the pixel and moves the chain mux.
  assign capture = (state == CAPTURE) && can_load;

  // Assemble the broadcast bus from the registered static fields and the load strobe.
  always_comb begin
    dnBCST                = {bcst_cfg_q, 1'b0};
    dnBCST[BCST_LOAD_BIT] = load_strobe;
  end

  // Static broadcast fields are re-registered so the whole bus leaves from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcst_cfg_q <= '0;
    end else begin
      bcst_cfg_q <= bcstCfg;
    end
  end

  // Scan state machine with its settle/read wait counter and the per-scan bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      load_strobe <= 1'b0;
      dnRead      <= 1'b0;
      scanDone    <= 1'b0;
      readCount   <= '0;
      overflow    <= 1'b0;
    end else begin
      scanDone <= 1'b0;
      case (state)
        IDLE: begin
          if (scanStart) begin
            readCount   <= '0;
            overflow    <= 1'b0;
            load_strobe <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          load_strobe <= 1'b0;
          wait_cnt    <= '0;
          state       <= SETTLE;
        end
        SETTLE: begin
          if (wait_cnt == SETTLE_LAST) begin
            wait_cnt <= '0;
            state    <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (!hit_pending) begin
            state <= DONE;
          end else if (readCount == READ_LIMIT) begin
            overflow <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (can_load) begin
            dnRead    <= 1'b1;
            readCount <= readCount + 1'b1;
            wait_cnt  <= '0;
            state     <= READ;
          end
        end
        READ: begin
          if (wait_cnt == READ_LAST) begin
            dnRead   <= 1'b0;
            wait_cnt <= '0;
            state    <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (wait_cnt == SETTLE_LAST) begin
            wait_cnt <= '0;
            state    <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          scanDone <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  col_readout_outreg #(
    .DATAWIDTH (DATAWIDTH)
  ) u_outreg (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .raw_data (dnData),
    .ready    (outReady),
    .word     (outData),
    .valid    (outValid),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_col_readout_sequencer.sv
// Self-checking bench for col_readout_sequencer with a behavioural switch-cell chain model.
// Build with COLRD_PARITY_EN defined to exercise the parity bit.
module tb_col_readout_sequencer;

  localparam int DW   = 46;
  localparam int HW   = 5;
  localparam int BW   = 12;
  localparam int SC   = 3;
  localparam int RC   = 2;
  localparam int MR   = 16;
  localparam int CW   = $clog2(MR + 1);
  localparam int NPIX = 20;
`ifdef COLRD_PARITY_EN
  localparam int OW = DW + 1;
`else
  localparam int OW = DW;
`endif

  logic          clk;
  logic          reset;
  logic          scanStart;
  logic [BW-2:0] bcstCfg;
  logic [HW-1:0] dnHits;
  logic [DW-1:0] dnData;
  logic          dnRead;
  logic [BW-1:0] dnBCST;
  logic [OW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          scanBusy;
  logic          scanDone;
  logic [CW-1:0] readCount;
  logic          overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_exp;

  logic [DW-1:0] pix_data [NPIX];
  logic          pend_hit [NPIX];
  logic          live_hit [NPIX];
  logic          read_q;
  logic [3:0]    trig_noise;
  int            clr_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  col_readout_sequencer #(
    .DATAWIDTH (DW),
    .HITSWIDTH (HW),
    .BCSTWIDTH (BW),
    .SETTLECYC (SC),
    .READCYC   (RC),
    .MAXREADS  (MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scanStart (scanStart),
    .bcstCfg   (bcstCfg),
    .dnHits    (dnHits),
    .dnData    (dnData),
    .dnRead    (dnRead),
    .dnBCST    (dnBCST),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .scanBusy  (scanBusy),
    .scanDone  (scanDone),
    .readCount (readCount),
    .overflow  (overflow)
  );

  // Chain output: OR of live hits, data from the lowest-index live pixel.
  always_comb begin
    logic found;
    found  = 1'b0;
    dnData = '0;
    dnHits = {trig_noise, 1'b0};
    for (int i = 0; i < NPIX; i++) begin
      if (live_hit[i] && !found) begin
        found  = 1'b1;
        dnData = pix_data[i];
      end
    end
    dnHits[0] = found;
  end

  // Chain state: load strobe copies pending hits; a read rising edge retires the selected pixel.
  always @(posedge clk) begin
    read_q <= dnRead;
    if (reset) begin
      for (int i = 0; i < NPIX; i++) live_hit[i] <= 1'b0;
    end else if (dnBCST[0]) begin
      for (int i = 0; i < NPIX; i++) live_hit[i] <= pend_hit[i];
    end else if (dnRead && !read_q) begin
      clr_idx = -1;
      for (int i = NPIX - 1; i >= 0; i--) if (live_hit[i]) clr_idx = i;
      if (clr_idx >= 0) live_hit[clr_idx] <= 1'b0;
    end
  end

  // Scoreboard: every accepted word must be the next one queued by the stimulus.
  always @(negedge clk) begin
    if (!reset && outValid && outReady) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL word_unexpected: got %0h, nothing expected", outData);
      end else begin
        mon_exp = exp_q.pop_front();
        if (outData !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL word_order: got %0h, expected %0h", outData, mon_exp);
        end
      end
    end
  end

  function automatic logic [OW-1:0] mk_word(input logic [DW-1:0] d);
`ifdef COLRD_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic clear_pixels();
    for (int i = 0; i < NPIX; i++) begin
      pix_data[i] = '0;
      pend_hit[i] = 1'b0;
    end
  endtask

  task automatic add_pixel(input int idx, input logic [DW-1:0] d, input bit expect_word);
    pix_data[idx] = d;
    pend_hit[idx] = 1'b1;
    if (expect_word) exp_q.push_back(mk_word(d));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    scanStart = 1'b1;
    @(posedge clk); #1;
    scanStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (scanDone) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bcstCfg  = 11'h7FF;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 8;
    if (dnRead !== 1'b0)     begin n_fail++; $display("[TB] FAIL rst_dnRead: got %0h, expected 0", dnRead); end
    if (dnBCST !== '0)       begin n_fail++; $display("[TB] FAIL rst_dnBCST: got %0h, expected 0", dnBCST); end
    if (outData !== '0)      begin n_fail++; $display("[TB] FAIL rst_outData: got %0h, expected 0", outData); end
    if (outValid !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_outValid: got %0h, expected 0", outValid); end
    if (scanBusy !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_scanBusy: got %0h, expected 0", scanBusy); end
    if (scanDone !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_scanDone: got %0h, expected 0", scanDone); end
    if (readCount !== '0)    begin n_fail++; $display("[TB] FAIL rst_readCount: got %0d, expected 0", readCount); end
    if (overflow !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_overflow: got %0h, expected 0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_zero_hits();
    int load_n = 0, done_n = 0, load_at = -1, done_at = -1, valid_n = 0, busy_n = 0;
    clear_pixels();
    bcstCfg = 11'h5A3;
    pulse_start();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (dnBCST[0]) begin load_n++; if (load_at < 0) load_at = c; end
      if (scanDone) begin done_n++; done_at = c; end
      if (outValid) valid_n++;
      if (scanBusy) busy_n++;
    end
    n_cmp += 7;
    if (load_n != 1)  begin n_fail++; $display("[TB] FAIL zero_load_pulse: got %0d cycles, expected 1", load_n); end
    if (done_n != 1)  begin n_fail++; $display("[TB] FAIL zero_done_pulse: got %0d cycles, expected 1", done_n); end
    if (done_at - load_at != SC + 3) begin
      n_fail++; $display("[TB] FAIL zero_done_latency: got %0d, expected %0d", done_at - load_at, SC + 3);
    end
    if (valid_n != 0) begin n_fail++; $display("[TB] FAIL zero_outValid: got %0d cycles, expected 0", valid_n); end
    if (busy_n != SC + 3) begin n_fail++; $display("[TB] FAIL zero_busy_len: got %0d, expected %0d", busy_n, SC + 3); end
    if (readCount !== '0) begin n_fail++; $display("[TB] FAIL zero_readCount: got %0d, expected 0", readCount); end
    if (dnBCST[BW-1:1] !== bcstCfg) begin
      n_fail++; $display("[TB] FAIL bcst_cfg: got %0h, expected %0h", dnBCST[BW-1:1], bcstCfg);
    end
  endtask

  task automatic test_three_hits();
    int load_n = 0, rd_rise = 0, rd_hi = 0, run = 0, bad_runs = 0;
    bit prev = 1'b0, done = 1'b0;
    clear_pixels();
    add_pixel(2, 46'h0AA, 1'b1);
    add_pixel(5, 46'h155, 1'b1);
    add_pixel(9, 46'h3FF, 1'b1);
    outReady = 1'b1;
    pulse_start();
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (c == 10) scanStart = 1'b1;
      if (c == 11) scanStart = 1'b0;
      if (dnBCST[0]) load_n++;
      if (dnRead) begin
        rd_hi++;
        run++;
        if (!prev) rd_rise++;
      end else begin
        if (prev && run != RC) bad_runs++;
        run = 0;
      end
      prev = dnRead;
      if (scanDone) done = 1'b1;
    end
    n_cmp += 8;
    if (!done)              begin n_fail++; $display("[TB] FAIL three_timeout: got no scanDone, expected one"); end
    if (rd_rise != 3)       begin n_fail++; $display("[TB] FAIL three_read_pulses: got %0d, expected 3", rd_rise); end
    if (rd_hi != 3 * RC)    begin n_fail++; $display("[TB] FAIL three_read_cycles: got %0d, expected %0d", rd_hi, 3 * RC); end
    if (bad_runs != 0)      begin n_fail++; $display("[TB] FAIL three_read_width: got %0d bad pulses, expected 0", bad_runs); end
    if (readCount !== CW'(3)) begin n_fail++; $display("[TB] FAIL three_readCount: got %0d, expected 3", readCount); end
    if (load_n != 1)        begin n_fail++; $display("[TB] FAIL busy_start_ignored: got %0d loads, expected 1", load_n); end
    if (exp_q.size() != 0)  begin n_fail++; $display("[TB] FAIL three_words_left: got %0d pending, expected 0", exp_q.size()); end
    if (overflow !== 1'b0)  begin n_fail++; $display("[TB] FAIL three_overflow: got %0h, expected 0", overflow); end
  endtask

  task automatic test_backpressure();
    int rise = 0, hold_bad = 0, total_rise = 1;
    bit seen = 1'b0, prev = 1'b1, done = 1'b0;
    clear_pixels();
    add_pixel(2, 46'h0AA, 1'b1);
    add_pixel(5, 46'h155, 1'b1);
    add_pixel(9, 46'h3FF, 1'b1);
    outReady = 1'b0;
    pulse_start();
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (outValid) seen = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (outData !== mk_word(46'h0AA) || !outValid) hold_bad++;
      if (dnRead && !prev) rise++;
      prev = dnRead;
    end
    n_cmp += 5;
    if (!seen)             begin n_fail++; $display("[TB] FAIL bp_first_word: got no outValid, expected one"); end
    if (rise != 0)         begin n_fail++; $display("[TB] FAIL bp_stall_read: got %0d reads, expected 0", rise); end
    if (hold_bad != 0)     begin n_fail++; $display("[TB] FAIL bp_hold: got %0d bad cycles, expected 0", hold_bad); end
    if (readCount !== CW'(1)) begin n_fail++; $display("[TB] FAIL bp_readCount: got %0d, expected 1", readCount); end
    if (scanBusy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_busy: got %0h, expected 1", scanBusy); end
    outReady = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (dnRead && !prev) total_rise++;
      prev = dnRead;
      if (scanDone) done = 1'b1;
    end
    n_cmp += 3;
    if (!done)             begin n_fail++; $display("[TB] FAIL bp_timeout: got no scanDone, expected one"); end
    if (total_rise != 3)   begin n_fail++; $display("[TB] FAIL bp_read_pulses: got %0d, expected 3", total_rise); end
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_words_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit seen = 1'b0;
    clear_pixels();
    add_pixel(0, 46'h123, 1'b0);
    add_pixel(1, 46'h456, 1'b0);
    outReady = 1'b0;
    pulse_start();
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (dnRead) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 5;
    if (!seen)              begin n_fail++; $display("[TB] FAIL mid_reach_read: got no dnRead, expected one"); end
    if (dnRead !== 1'b0)    begin n_fail++; $display("[TB] FAIL mid_dnRead: got %0h, expected 0", dnRead); end
    if (outValid !== 1'b0)  begin n_fail++; $display("[TB] FAIL mid_outValid: got %0h, expected 0", outValid); end
    if (scanBusy !== 1'b0)  begin n_fail++; $display("[TB] FAIL mid_scanBusy: got %0h, expected 0", scanBusy); end
    if (readCount !== '0)   begin n_fail++; $display("[TB] FAIL mid_readCount: got %0d, expected 0", readCount); end
    reset = 1'b0;
    outReady = 1'b1;
  endtask

  task automatic test_exact_max();
    bit done;
    clear_pixels();
    for (int i = 0; i < MR; i++) add_pixel(i, DW'(i * 977 + 5), 1'b1);
    outReady = 1'b1;
    pulse_start();
    wait_done(1000, done);
    n_cmp += 4;
    if (!done)                begin n_fail++; $display("[TB] FAIL max_timeout: got no scanDone, expected one"); end
    if (overflow !== 1'b0)    begin n_fail++; $display("[TB] FAIL max_overflow: got %0h, expected 0", overflow); end
    if (readCount !== CW'(MR)) begin n_fail++; $display("[TB] FAIL max_readCount: got %0d, expected %0d", readCount, MR); end
    if (exp_q.size() != 0)    begin n_fail++; $display("[TB] FAIL max_words_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    bit done;
    clear_pixels();
    for (int i = 0; i <= MR; i++) add_pixel(i, DW'(i * 37 + 1), i < MR);
    outReady = 1'b1;
    pulse_start();
    wait_done(1000, done);
    n_cmp += 4;
    if (!done)                begin n_fail++; $display("[TB] FAIL ovf_timeout: got no scanDone, expected one"); end
    if (overflow !== 1'b1)    begin n_fail++; $display("[TB] FAIL ovf_flag: got %0h, expected 1", overflow); end
    if (readCount !== CW'(MR)) begin n_fail++; $display("[TB] FAIL ovf_readCount: got %0d, expected %0d", readCount, MR); end
    if (exp_q.size() != 0)    begin n_fail++; $display("[TB] FAIL ovf_words_left: got %0d pending, expected 0", exp_q.size()); end
    clear_pixels();
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %0h, expected 0", overflow); end
    wait_done(30, done);
    n_cmp++;
    if (!done || readCount !== '0) begin
      n_fail++; $display("[TB] FAIL ovf_rescan: got done=%0d count=%0d, expected done=1 count=0", done, readCount);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] pd [2];
    logic [OW-1:0] w;
    bit seen, done;
    pd[0] = 46'h3;
    pd[1] = 46'h1;
    for (int k = 0; k < 2; k++) begin
      clear_pixels();
      add_pixel(4, pd[k], 1'b1);
      w = mk_word(pd[k]);
      outReady = 1'b1;
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clk);
        if (outValid) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || outData[OW-1] !== w[OW-1]) begin
        n_fail++; $display("[TB] FAIL parity_msb: got %0h (valid %0d), expected %0h", outData[OW-1], seen, w[OW-1]);
      end
      wait_done(30, done);
      n_cmp++;
      if (!done) begin n_fail++; $display("[TB] FAIL parity_timeout: got no scanDone, expected one"); end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    scanStart  = 1'b0;
    bcstCfg    = '0;
    outReady   = 1'b0;
    trig_noise = 4'hA;
    clear_pixels();
    test_reset();
    test_zero_hits();
    test_three_hits();
    trig_noise = 4'h5;
    test_backpressure();
    test_reset_mid_read();
    test_exact_max();
    test_overflow();
    test_parity();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/col_readout_sequencer.md
Name: col_readout_sequencer

Overview:
- Clocked controller at the bottom (downstream end) of one pixel column's switch-cell chain.
- On a scan request it:
  - issues a broadcast load strobe up the chain;
  - waits for the chain to settle;
  - repeatedly captures the chain's priority-selected data word while the aggregated unread-hit flag is set;
  - pulses the read line to retire that pixel.
- Captured words leave through a valid/ready handshake toward the global readout.

Parameters:
- DATAWIDTH, 46, width of chain data word
- HITSWIDTH, 5, width of chain hit vector; bit 0 = unread hit, bits [4:1] = trigger hits
- BCSTWIDTH, 12, width of broadcast bus; bit 0 = load strobe
- SETTLECYC, 3, clk cycles waited after any chain-driving change before sampling chain outputs, minimum 1
- READCYC, 2, clk cycles dnRead is held high per pixel, minimum 1
- MAXREADS, 16, pixels per column; reads per scan are limited to this number

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scanStart  in  1  one-cycle request to start a column scan; ignored unless in IDLE
- bcstCfg  in  BCSTWIDTH-1  static broadcast fields, passed to dnBCST[BCSTWIDTH-1:1]
- dnHits  in  HITSWIDTH  OR-aggregated hit vector from chain
- dnData  in  DATAWIDTH  priority-muxed data from chain
- dnRead  out  1  read pulse into chain
- dnBCST  out  BCSTWIDTH  broadcast bus into chain
- outData  out  DATAWIDTH (+1 with parity feature)  captured word
- outValid  out  1  outData valid
- outReady  in  1  consumer accepts when outValid and outReady are both high
- scanBusy  out  1  high in any state except IDLE
- scanDone  out  1  one-cycle pulse at end of scan
- readCount  out  $clog2(MAXREADS+1)  pixels read in the current or last scan
- overflow  out  1  sticky; hit still set after MAXREADS reads; cleared by scanStart

Behaviour:
- Reset: all outputs are 0.
  - The state machine goes to IDLE; counters clear.
  - Reset mid-scan aborts at once: dnRead drops the next cycle and any pending outValid is discarded.
- Outputs are registered: dnRead, dnBCST[0], outValid and scanDone all come from flops.
- dnBCST[BCSTWIDTH-1:1] = bcstCfg (registered).
- States:
  - IDLE:
    - On scanStart: clear readCount and overflow, go to LOAD.
  - LOAD:
    - dnBCST[0] = 1 for exactly 1 cycle, then go to SETTLE.
  - SETTLE:
    - Wait SETTLECYC cycles, then go to CHECK.
  - CHECK (samples dnHits[0]):
    - If dnHits[0] = 0: go to DONE.
    - Else if readCount == MAXREADS: set overflow, go to DONE.
    - Else: go to CAPTURE.
  - CAPTURE:
    - If outValid = 0, or outValid and outReady are both high this cycle: latch dnData into outData, set outValid, go to READ.
    - Otherwise stall in CAPTURE. dnRead stays low.
  - READ:
    - dnRead = 1 for READCYC cycles.
    - readCount increments on the cycle dnRead is first asserted.
    - Then go to RELEASE.
  - RELEASE:
    - dnRead = 0; wait SETTLECYC cycles, then go to CHECK.
  - DONE:
    - scanDone = 1 for 1 cycle, then go to IDLE.
    - outValid may still be pending; it is held until accepted.
- outValid is cleared on handshake unless CAPTURE reloads it in the same cycle. Back-to-back accept plus reload gives no bubble.
- Data is captured before dnRead, because the pixel clears its hit on read and the chain mux then moves.
- Boundary cases:
  - Zero hits: LOAD, SETTLE, CHECK, DONE; readCount = 0.
  - Exactly MAXREADS hits: overflow = 0 if dnHits[0] is 0 at the final CHECK.
  - scanStart while busy is ignored.
  - A scanStart in the same cycle as the DONE→IDLE transition is ignored.
- dnHits[4:1] is ignored by this block.

Optional Feature:
- COLRD_PARITY_EN
  - Defined: outData is DATAWIDTH+1 bits; the MSB is even parity (XOR) of dnData, computed at capture.
  - Undefined: outData is exactly DATAWIDTH bits and no parity logic exists.

Decomposition:
- Package col_readout_pkg:
  - state enum (IDLE, LOAD, SETTLE, CHECK, CAPTURE, READ, RELEASE, DONE);
  - BCST_LOAD_BIT = 0;
  - UNREAD_HIT_BIT = 0.
- Sub-module: one natural piece, col_readout_outreg.
  - Output holding register with its valid/ready logic and the optional parity bit.
- The FSM and wait counters stay in the top module.

Test Plan:
1. Reset mid-READ (dnRead=1) → next cycle dnRead=0, outValid=0, scanBusy=0, readCount=0.
2. scanStart with dnHits=0 → dnBCST[0] high 1 cycle; scanDone exactly 1+SETTLECYC+2 cycles after LOAD; readCount=0, no outValid.
3. Chain model with 3 hit pixels holding data 0x0AA, 0x155, 0x3FF, outReady=1 → three words in priority order; exactly 3 dnRead pulses of READCYC cycles each; readCount=3; scanDone.
4. Same model with outReady=0 for 20 cycles after the first word → FSM stalls in CAPTURE; dnRead stays 0; the second word appears only after the first handshake; no word lost or duplicated.
5. Model with 17 hits, MAXREADS=16 → 16 words; overflow=1; scanDone; the next scanStart clears overflow.
6. COLRD_PARITY_EN with dnData=0x3 → outData MSB=0; dnData=0x1 → MSB=1. Without the macro, outData is 46 bits wide.
